learn_step_controller: RTL and testbench

- Sequences one learning-mode session: walks the song memory, plays each guide note on the buzzer for its stored duration, then waits for the player to enter and confirm a note.
- Judges each entry as hit or miss, keeps a saturating score, and advances or ends the song.
- Sits between song memory (address out, note/duration/valid in) and the buzzer, score display and LED blocks.

---
 rtl/learn_step_controller.sv | 232 +++++++++++++++++++++++
 tb/tb_learn_step_controller.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/learn_step_controller.sv
// learn_step_controller: sequences a learning-mode session (guide note, wait for entry, judge, advance).
// Optional LEARN_RETRY_EN: a missed note is replayed, up to three attempts per note.
module learn_step_controller #(
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned SONG_LEN    = 32,
    parameter int unsigned TIMEOUT_CYC = 500_000_000,
    parameter int unsigned SCORE_MAX   = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        note_value,
    input  logic [25:0]       duration_value,
    input  logic              isvalid,
    input  logic [3:0]        user_input,
    input  logic              confirm_button,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              key_on,
    output logic [3:0]        key,
    output logic [4:0]        score,
    output logic              busy,
    output logic              done,
    output logic              hit,
    output logic              miss
);
    localparam int unsigned NOTE_W  = 4;
    localparam int unsigned DUR_W   = 26;
    localparam int unsigned SCORE_W = 5;
    localparam int unsigned TO_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(SONG_LEN - 1);
    localparam logic [SCORE_W-1:0] SCORE_TOP = SCORE_W'(SCORE_MAX);
    localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_GUIDE,
        S_WAIT_IN,
        S_JUDGE,
        S_ADVANCE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                start_q, confirm_q;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [NOTE_W-1:0]   key_q, key_d;
    logic                key_on_q, key_on_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                hit_q, hit_d;
    logic                miss_q, miss_d;
    logic [DUR_W-1:0]    dur_cnt_q, dur_cnt_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [NOTE_W-1:0]   cap_q, cap_d;
    logic                entered_q, entered_d;
    logic [DUR_W-1:0]    guide_len_c;
    logic                start_edge_c;
    logic                confirm_edge_c;
    logic                judge_hit_c;
`ifdef LEARN_RETRY_EN
    logic [1:0]          attempt_q, attempt_d;
    logic [DUR_W-1:0]    dur_len_q, dur_len_d;
`endif

    assign start_edge_c   = start & ~start_q;
    assign confirm_edge_c = confirm_button & ~confirm_q;
    assign guide_len_c    = (duration_value == '0) ? DUR_W'(1) : duration_value;
    // A timeout leaves entered_q clear, which forces the miss.
    assign judge_hit_c    = entered_q && (cap_q == key_q);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            start_q    <= 1'b0;
            confirm_q  <= 1'b0;
            mem_addr_q <= '0;
            key_q      <= '0;
            key_on_q   <= 1'b0;
            score_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            dur_cnt_q  <= '0;
            to_cnt_q   <= '0;
            cap_q      <= '0;
            entered_q  <= 1'b0;
`ifdef LEARN_RETRY_EN
            attempt_q  <= '0;
            dur_len_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            start_q    <= start;
            confirm_q  <= confirm_button;
            mem_addr_q <= mem_addr_d;
            key_q      <= key_d;
            key_on_q   <= key_on_d;
            score_q    <= score_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            dur_cnt_q  <= dur_cnt_d;
            to_cnt_q   <= to_cnt_d;
            cap_q      <= cap_d;
            entered_q  <= entered_d;
`ifdef LEARN_RETRY_EN
            attempt_q  <= attempt_d;
            dur_len_q  <= dur_len_d;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        key_d      = key_q;
        key_on_d   = key_on_q;
        score_d    = score_q;
        busy_d     = busy_q;
        done_d     = done_q;
        hit_d      = 1'b0;
        miss_d     = 1'b0;
        dur_cnt_d  = dur_cnt_q;
        to_cnt_d   = to_cnt_q;
        cap_d      = cap_q;
        entered_d  = entered_q;
`ifdef LEARN_RETRY_EN
        attempt_d  = attempt_q;
        dur_len_d  = dur_len_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_edge_c) begin
                    state_d    = S_FETCH;
                    mem_addr_d = '0;
                    score_d    = '0;
                    done_d     = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            S_FETCH: begin
                if (!isvalid) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d   = S_GUIDE;
                    key_d     = note_value;
                    dur_cnt_d = guide_len_c;
                    key_on_d  = 1'b1;
`ifdef LEARN_RETRY_EN
                    dur_len_d = guide_len_c;
`endif
                end
            end
            S_GUIDE: begin
                if (dur_cnt_q <= DUR_W'(1)) begin
                    state_d  = S_WAIT_IN;
                    key_on_d = 1'b0;
                    to_cnt_d = '0;
                end else begin
                    dur_cnt_d = dur_cnt_q - DUR_W'(1);
                end
            end
            S_WAIT_IN: begin
                // Confirm is checked first so it wins over a simultaneous timeout.
                if (confirm_edge_c) begin
                    state_d   = S_JUDGE;
                    cap_d     = user_input;
                    entered_d = 1'b1;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d   = S_JUDGE;
                    entered_d = 1'b0;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_JUDGE: begin
                state_d = S_ADVANCE;
                if (judge_hit_c) begin
                    hit_d = 1'b1;
                    if (score_q < SCORE_TOP) begin
                        score_d = score_q + SCORE_W'(1);
                    end
                end else begin
                    miss_d = 1'b1;
`ifdef LEARN_RETRY_EN
                    if (attempt_q != 2'd2) begin
                        state_d   = S_GUIDE;
                        attempt_d = attempt_q + 2'd1;
                        dur_cnt_d = dur_len_q;
                        key_on_d  = 1'b1;
                    end
`endif
                end
            end
            S_ADVANCE: begin
`ifdef LEARN_RETRY_EN
                attempt_d = '0;
`endif
                if (mem_addr_q == LAST_ADDR) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d    = S_FETCH;
                    mem_addr_d = mem_addr_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_addr = mem_addr_q;
    assign key_on   = key_on_q;
    assign key      = key_q;
    assign score    = score_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign hit      = hit_q;
    assign miss     = miss_q;

endmodule

// File: tb/tb_learn_step_controller.sv
// tb_learn_step_controller: scoreboard bench for learn_step_controller (main DUT SONG_LEN=4, second DUT SONG_LEN=32).
// Define LEARN_RETRY_EN to build and check the retry variant.
`timescale 1ns/1ps
module tb_learn_step_controller;
    localparam int unsigned ADDR_W      = 5;
    localparam int unsigned TIMEOUT_CYC = 50;
`ifdef LEARN_RETRY_EN
    localparam int ATTEMPTS = 3;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              start, confirm_button, isvalid;
    logic [3:0]        note_value, user_input, key;
    logic [25:0]       duration_value;
    logic [ADDR_W-1:0] mem_addr;
    logic [4:0]        score;
    logic              key_on, busy, done, hit, miss;

    logic              start_s, confirm_s, key_on_s, busy_s, done_s, hit_s, miss_s;
    logic [3:0]        user_s, key_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [4:0]        score_s;

    logic [3:0]  mem_note  [32];
    logic [25:0] mem_dur   [32];
    logic        mem_valid [32];

    int checks = 0;
    int errors = 0;
    bit exp_q[$];
    bit exp;

    int         glen, wlen;
    logic [3:0] kseen;
    bit         ghit, gmiss, kpulse, onec, ok;

    always #5 clk = ~clk;

    assign note_value     = mem_note[mem_addr];
    assign duration_value = mem_dur[mem_addr];
    assign isvalid        = mem_valid[mem_addr];

    learn_step_controller #(.ADDR_W(ADDR_W), .SONG_LEN(4), .TIMEOUT_CYC(TIMEOUT_CYC), .SCORE_MAX(31)) u_dut (
        .clk(clk), .rst(rst), .start(start), .note_value(note_value),
        .duration_value(duration_value), .isvalid(isvalid), .user_input(user_input),
        .confirm_button(confirm_button), .mem_addr(mem_addr), .key_on(key_on), .key(key),
        .score(score), .busy(busy), .done(done), .hit(hit), .miss(miss)
    );

    learn_step_controller #(.ADDR_W(ADDR_W), .SONG_LEN(32), .TIMEOUT_CYC(TIMEOUT_CYC), .SCORE_MAX(31)) u_sat (
        .clk(clk), .rst(rst), .start(start_s), .note_value(mem_addr_s[3:0]),
        .duration_value(26'd1), .isvalid(1'b1), .user_input(user_s),
        .confirm_button(confirm_s), .mem_addr(mem_addr_s), .key_on(key_on_s), .key(key_s),
        .score(score_s), .busy(busy_s), .done(done_s), .hit(hit_s), .miss(miss_s)
    );

    task automatic load_mem();
        for (int i = 0; i < 32; i++) begin
            mem_note[i]  = 4'd0;
            mem_dur[i]   = 26'd1;
            mem_valid[i] = 1'b1;
        end
        mem_note[0] = 4'd3; mem_dur[0] = 26'd5;
        mem_note[1] = 4'd7; mem_dur[1] = 26'd2;
        mem_note[2] = 4'd1; mem_dur[2] = 26'd0;
        mem_note[3] = 4'd9; mem_dur[3] = 26'd4;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Plays one note: optional wait for the guide, optional press, then waits for the judgement pulse.
    task automatic run_note(input logic [3:0] ans, input bit press, input bit wait_guide,
                            output int gl, output int wl, output logic [3:0] ks,
                            output bit gh, output bit gm, output bit kp, output bit one, output bit okay);
        okay = 1'b1; gl = 0; wl = 0; ks = 4'd0; gh = 1'b0; gm = 1'b0; kp = 1'b0; one = 1'b0;
        if (wait_guide) begin
            for (int i = 0; i < 200 && !key_on; i++) @(negedge clk);
            if (!key_on) begin okay = 1'b0; return; end
            ks = key;
            while (key_on && gl < 200) begin gl++; @(negedge clk); end
        end
        if (press) begin user_input = ans; confirm_button = 1'b1; end
        while (!(hit || miss) && wl < 300) begin
            @(negedge clk);
            wl++;
            confirm_button = 1'b0;
        end
        if (!(hit || miss)) begin okay = 1'b0; return; end
        gh = hit; gm = miss; kp = key_on;
        @(negedge clk);
        one = !(hit || miss);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; confirm_button = 1'b0; user_input = 4'd0;
        start_s = 1'b0; confirm_s = 1'b0; user_s = 4'd0;
        load_mem();
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({mem_addr, key_on, key, score, busy, done, hit, miss} !== '0) begin
            errors++;
            $display("FAIL reset_async: outputs=%h wanted 0", {mem_addr, key_on, key, score, busy, done, hit, miss});
        end
        @(negedge clk);
        checks++;
        if ({mem_addr_s, key_on_s, key_s, score_s, busy_s, done_s, hit_s, miss_s} !== '0) begin
            errors++;
            $display("FAIL reset_sat: outputs=%h wanted 0", {mem_addr_s, key_on_s, key_s, score_s, busy_s, done_s, hit_s, miss_s});
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: busy=%b done=%b wanted 0 0", busy, done);
        end
    endtask

    task automatic test_play_all();
        do_start();
        checks++;
        if (busy !== 1'b1 || mem_addr !== 5'd0 || score !== 5'd0) begin
            errors++;
            $display("FAIL start: busy=%b addr=%0d score=%0d wanted 1 0 0", busy, mem_addr, score);
        end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(1'b1);
            run_note(mem_note[i], 1'b1, 1'b1, glen, wlen, kseen, ghit, gmiss, kpulse, onec, ok);
            exp = exp_q.pop_front();
            checks++;
            if (!ok || ghit !== exp || gmiss !== !exp) begin
                errors++;
                $display("FAIL play_judge%0d: hit=%b miss=%b ok=%b wanted hit=%b", i, ghit, gmiss, ok, exp);
            end
            checks++;
            if (glen !== ((mem_dur[i] == 0) ? 1 : int'(mem_dur[i]))) begin
                errors++;
                $display("FAIL play_guide_len%0d: got %0d wanted %0d", i, glen, (mem_dur[i] == 0) ? 1 : int'(mem_dur[i]));
            end
            checks++;
            if (kseen !== mem_note[i] || wlen !== 2 || !onec) begin
                errors++;
                $display("FAIL play_key%0d: key=%0d wait=%0d one=%b wanted key=%0d wait=2 one=1", i, kseen, wlen, onec, mem_note[i]);
            end
        end
        checks++;
        if (score !== 5'd4 || mem_addr !== 5'd3 || done !== 1'b1 || busy !== 1'b0 || key_on !== 1'b0) begin
            errors++;
            $display("FAIL play_end: score=%0d addr=%0d done=%b busy=%b key_on=%b wanted 4 3 1 0 0", score, mem_addr, done, busy, key_on);
        end
    endtask

    task automatic test_wrong_timeout();
        do_start();
        checks++;
        if (busy !== 1'b1 || mem_addr !== 5'd0 || score !== 5'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL restart: busy=%b addr=%0d score=%0d done=%b wanted 1 0 0 0", busy, mem_addr, score, done);
        end
        for (int a = 0; a < ATTEMPTS; a++) begin
            exp_q.push_back(1'b0);
            run_note(4'd2, 1'b1, 1'b1, glen, wlen, kseen, ghit, gmiss, kpulse, onec, ok);
            exp = exp_q.pop_front();
            checks++;
            if (!ok || ghit !== exp || gmiss !== !exp || !onec) begin
                errors++;
                $display("FAIL wrong_judge: hit=%b miss=%b ok=%b one=%b wanted miss", ghit, gmiss, ok, onec);
            end
        end
        for (int a = 0; a < ATTEMPTS; a++) begin
            exp_q.push_back(1'b0);
            run_note(4'd0, 1'b0, 1'b1, glen, wlen, kseen, ghit, gmiss, kpulse, onec, ok);
            exp = exp_q.pop_front();
            checks++;
            if (!ok || ghit !== exp || gmiss !== !exp) begin
                errors++;
                $display("FAIL timeout_judge: hit=%b miss=%b ok=%b wanted miss", ghit, gmiss, ok);
            end
            // TIMEOUT_CYC cycles in WAIT_IN, then one JUDGE cycle before the pulse shows.
            checks++;
            if (wlen !== TIMEOUT_CYC + 1) begin
                errors++;
                $display("FAIL timeout_len: got %0d wanted %0d", wlen, TIMEOUT_CYC + 1);
            end
        end
        checks++;
        if (score !== 5'd0 || mem_addr !== 5'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL after_miss: score=%0d addr=%0d busy=%b wanted 0 2 1", score, mem_addr, busy);
        end
        for (int i = 2; i < 4; i++) begin
            exp_q.push_back(1'b1);
            run_note(mem_note[i], 1'b1, 1'b1, glen, wlen, kseen, ghit, gmiss, kpulse, onec, ok);
            exp = exp_q.pop_front();
            checks++;
            if (!ok || ghit !== exp || gmiss !== !exp) begin
                errors++;
                $display("FAIL rest_judge%0d: hit=%b miss=%b ok=%b wanted hit", i, ghit, gmiss, ok);
            end
        end
        checks++;
        if (score !== 5'd2 || done !== 1'b1) begin
            errors++;
            $display("FAIL wrong_end: score=%0d done=%b wanted 2 1", score, done);
        end
    endtask

    task automatic test_early_press();
        int pulses = 0;
        int n = 0;
        do_start();
        for (int i = 0; i < 50 && !key_on; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        user_input = 4'd3;
        confirm_button = 1'b1;
        while (key_on && n < 50) begin n++; @(negedge clk); end
        repeat (8) begin
            if (hit || miss) pulses++;
            @(negedge clk);
        end
        checks++;
        if (pulses !== 0 || key_on !== 1'b0) begin
            errors++;
            $display("FAIL early_press: pulses=%0d key_on=%b wanted 0 0", pulses, key_on);
        end
        confirm_button = 1'b0;
        @(negedge clk);
        exp_q.push_back(1'b1);
        run_note(4'd3, 1'b1, 1'b0, glen, wlen, kseen, ghit, gmiss, kpulse, onec, ok);
        exp = exp_q.pop_front();
        checks++;
        if (!ok || ghit !== exp || gmiss !== !exp || !onec || score !== 5'd1 || mem_addr !== 5'd1) begin
            errors++;
            $display("FAIL repress: hit=%b miss=%b one=%b score=%0d addr=%0d wanted hit one=1 score=1 addr=1",
                     ghit, gmiss, onec, score, mem_addr);
        end
    endtask

    task automatic test_abort();
        for (int i = 0; i < 50 && !key_on; i++) @(negedge clk);
        checks++;
        if (key_on !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_guide: key_on=%b busy=%b wanted 1 1", key_on, busy);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({mem_addr, key_on, key, score, busy, done, hit, miss} !== '0) begin
            errors++;
            $display("FAIL abort_reset: outputs=%h wanted 0", {mem_addr, key_on, key, score, busy, done, hit, miss});
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || key_on !== 1'b0 || hit !== 1'b0 || miss !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b key_on=%b hit=%b miss=%b wanted 0", busy, key_on, hit, miss);
        end
    endtask

    task automatic test_end_marker();
        load_mem();
        mem_valid[1] = 1'b0;
        do_start();
        exp_q.push_back(1'b1);
        run_note(4'd3, 1'b1, 1'b1, glen, wlen, kseen, ghit, gmiss, kpulse, onec, ok);
        exp = exp_q.pop_front();
        checks++;
        if (!ok || ghit !== exp || gmiss !== !exp) begin
            errors++;
            $display("FAIL marker_judge: hit=%b miss=%b ok=%b wanted hit", ghit, gmiss, ok);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || score !== 5'd1 || mem_addr !== 5'd1 || key_on !== 1'b0) begin
            errors++;
            $display("FAIL marker_done: done=%b busy=%b score=%0d addr=%0d key_on=%b wanted 1 0 1 1 0",
                     done, busy, score, mem_addr, key_on);
        end
        mem_valid[1] = 1'b1;
    endtask

    task automatic test_saturation();
        int hits = 0;
        bit stuck = 1'b0;
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        for (int i = 0; i < 32 && !stuck; i++) begin
            for (int t = 0; t < 20 && !key_on_s; t++) @(negedge clk);
            if (key_s !== 4'(i) && key_on_s) begin
                errors++;
                $display("FAIL sat_key%0d: got %0d wanted %0d", i, key_s, 4'(i));
            end
            for (int t = 0; t < 20 && key_on_s; t++) @(negedge clk);
            user_s = 4'(i);
            confirm_s = 1'b1;
            exp_q.push_back(1'b1);
            @(negedge clk);
            confirm_s = 1'b0;
            for (int t = 0; t < 20 && !(hit_s || miss_s); t++) @(negedge clk);
            exp = exp_q.pop_front();
            checks++;
            if (hit_s !== exp || miss_s !== !exp) begin
                errors++;
                stuck = !(hit_s || miss_s);
                $display("FAIL sat_judge%0d: hit=%b miss=%b wanted hit", i, hit_s, miss_s);
            end
            if (hit_s) hits++;
        end
        @(negedge clk);
        checks++;
        if (hits !== 32 || score_s !== 5'd31 || done_s !== 1'b1 || mem_addr_s !== 5'd31) begin
            errors++;
            $display("FAIL saturate: hits=%0d score=%0d done=%b addr=%0d wanted 32 31 1 31", hits, score_s, done_s, mem_addr_s);
        end
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        checks++;
        if (score_s !== 5'd0 || mem_addr_s !== 5'd0 || busy_s !== 1'b1 || done_s !== 1'b0) begin
            errors++;
            $display("FAIL sat_restart: score=%0d addr=%0d busy=%b done=%b wanted 0 0 1 0", score_s, mem_addr_s, busy_s, done_s);
        end
    endtask

`ifdef LEARN_RETRY_EN
    task automatic test_retry();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        load_mem();
        do_start();
        for (int a = 0; a < 3; a++) begin
            exp_q.push_back(1'b0);
            run_note(4'd2, 1'b1, 1'b1, glen, wlen, kseen, ghit, gmiss, kpulse, onec, ok);
            exp = exp_q.pop_front();
            checks++;
            if (!ok || ghit !== exp || gmiss !== !exp || !onec) begin
                errors++;
                $display("FAIL retry_judge%0d: hit=%b miss=%b ok=%b one=%b wanted miss", a, ghit, gmiss, ok, onec);
            end
            // Replayed guide: the pulse and trailing samples already took its first cycle.
            checks++;
            if ((a < 2 && kpulse !== 1'b1) || (a == 2 && kpulse !== 1'b0) || (a > 0 && glen !== 4)) begin
                errors++;
                $display("FAIL retry_replay%0d: key_on_at_pulse=%b guide=%0d", a, kpulse, glen);
            end
        end
        checks++;
        if (mem_addr !== 5'd1 || score !== 5'd0) begin
            errors++;
            $display("FAIL retry_advance: addr=%0d score=%0d wanted 1 0", mem_addr, score);
        end
        exp_q.push_back(1'b1);
        run_note(4'd7, 1'b1, 1'b1, glen, wlen, kseen, ghit, gmiss, kpulse, onec, ok);
        exp = exp_q.pop_front();
        checks++;
        if (!ok || ghit !== exp || gmiss !== !exp || glen !== 2 || score !== 5'd1) begin
            errors++;
            $display("FAIL retry_next: hit=%b guide=%0d score=%0d wanted hit 2 1", ghit, glen, score);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_play_all();
        test_wrong_timeout();
        test_early_press();
        test_abort();
        test_end_marker();
        test_saturation();
`ifdef LEARN_RETRY_EN
        test_retry();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
